// File: rtl/dcfifo_mixed_widths.sv
// rtl/dcfifo_mixed_widths.sv - single-clock mixed-width FIFO, 2:1 write-to-read width
// Optional sticky overflow/underflow outputs under DCFIFO_MW_ERRFLAG_EN.
module dcfifo_mixed_widths #(
    parameter int lpm_width     = 64,
    parameter int lpm_width_r   = 32,
    parameter int lpm_numwords  = 512,
    parameter int lpm_widthu    = 9,
    parameter int lpm_widthu_r  = 10,
    parameter     lpm_showahead = "ON"
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [lpm_width-1:0]    data,
    input  logic                    wrreq,
    input  logic                    rdreq,
    output logic [lpm_width_r-1:0]  q,
    output logic                    wrfull,
    output logic                    rdfull,
    output logic                    wrempty,
    output logic                    rdempty,
    output logic [lpm_widthu-1:0]   wrusedw,
    output logic [lpm_widthu_r-1:0] rdusedw
`ifdef DCFIFO_MW_ERRFLAG_EN
    ,
    output logic                    overflow,
    output logic                    underflow
`endif
);

    localparam int             CW        = lpm_widthu_r + 1;
    localparam logic [CW-1:0]  CAP       = CW'(2 * lpm_numwords);
    localparam bit             SHOWAHEAD = (lpm_showahead == "ON");

    logic [lpm_width-1:0]    mem [lpm_numwords];
    logic [lpm_width-1:0]    ram_rd_q;

    logic [lpm_widthu-1:0]   wr_ptr_q, wr_ptr_d;
    logic [lpm_widthu_r-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    empty_q, empty_d;
    logic                    rdfull_q, rdfull_d;
    logic                    wrfull_q, wrfull_d;
    logic                    byp_sel_q, byp_sel_d;
    logic [lpm_width-1:0]    byp_data_q, byp_data_d;
    logic [lpm_width_r-1:0]  q_q, q_d;
    logic [lpm_width-1:0]    head_word;
    logic [lpm_width_r-1:0]  head;
    logic                    wr_acc, rd_acc;

    always_comb begin
        wr_acc    = wrreq & ~wrfull_q;
        rd_acc    = rdreq & ~empty_q;
        wr_ptr_d  = wr_ptr_q + lpm_widthu'(wr_acc);
        rd_ptr_d  = rd_ptr_q + lpm_widthu_r'(rd_acc);
        cnt_d     = cnt_q + CW'({wr_acc, 1'b0}) - CW'(rd_acc);
        empty_d   = (cnt_d == '0);
        rdfull_d  = (cnt_d == CAP);
        wrfull_d  = (cnt_d >= CAP - CW'(1));
        // The RAM read below sees pre-write contents, so forward a word
        // landing in the slot the head is about to read from.
        byp_sel_d  = wr_acc && (wr_ptr_q == rd_ptr_d[lpm_widthu_r-1:1]);
        byp_data_d = data;
        head_word  = byp_sel_q ? byp_data_q : ram_rd_q;
        head       = rd_ptr_q[0] ? head_word[lpm_width-1:lpm_width_r]
                                 : head_word[lpm_width_r-1:0];
        q_d        = rd_acc ? head : q_q;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data;
        end
        ram_rd_q <= mem[rd_ptr_d[lpm_widthu_r-1:1]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            empty_q    <= 1'b1;
            rdfull_q   <= 1'b0;
            wrfull_q   <= 1'b0;
            byp_sel_q  <= 1'b0;
            byp_data_q <= '0;
            q_q        <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            empty_q    <= empty_d;
            rdfull_q   <= rdfull_d;
            wrfull_q   <= wrfull_d;
            byp_sel_q  <= byp_sel_d;
            byp_data_q <= byp_data_d;
            q_q        <= q_d;
        end
    end

    assign q       = SHOWAHEAD ? (empty_q ? '0 : head) : q_q;
    assign wrfull  = wrfull_q;
    assign rdfull  = rdfull_q;
    assign wrempty = empty_q;
    assign rdempty = empty_q;
    assign rdusedw = cnt_q[lpm_widthu_r-1:0];
    assign wrusedw = cnt_q[lpm_widthu_r-1:1];

`ifdef DCFIFO_MW_ERRFLAG_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (wrreq & wrfull_q);
        udf_d = udf_q | (rdreq & empty_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_dcfifo_mixed_widths.sv
// tb/tb_dcfifo_mixed_widths.sv - directed self-checking bench for dcfifo_mixed_widths
module tb_dcfifo_mixed_widths;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] data;
    logic        wrreq;
    logic        rdreq;
    logic [31:0] q;
    logic        wrfull, rdfull, wrempty, rdempty;
    logic [8:0]  wrusedw;
    logic [9:0]  rdusedw;
`ifdef DCFIFO_MW_ERRFLAG_EN
    logic        overflow, underflow;
`endif

    int checks   = 0;
    int failures = 0;

    dcfifo_mixed_widths dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .wrreq   (wrreq),
        .rdreq   (rdreq),
        .q       (q),
        .wrfull  (wrfull),
        .rdfull  (rdfull),
        .wrempty (wrempty),
        .rdempty (rdempty),
        .wrusedw (wrusedw),
        .rdusedw (rdusedw)
`ifdef DCFIFO_MW_ERRFLAG_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic [63:0] d, input logic r);
        wrreq = w;
        data  = d;
        rdreq = r;
        @(posedge clk);
        #1;
        wrreq = 1'b0;
        rdreq = 1'b0;
        data  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 64'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic fill_all();
        for (int k = 0; k < 512; k++) begin
            step(1'b1, {32'(2 * k + 1), 32'(2 * k)}, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        wrreq = 1'b0;
        rdreq = 1'b0;
        data  = '0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_rdempty", rdempty, 1);
        check("rst_wrempty", wrempty, 1);
        check("rst_rdfull",  rdfull,  0);
        check("rst_wrfull",  wrfull,  0);
        check("rst_rdusedw", rdusedw, 0);
        check("rst_wrusedw", wrusedw, 0);
        check("rst_q",       q,       0);

        // First write falls through
        step(1'b1, 64'h00000001_00000000, 1'b0);
        check("fw_rdempty", rdempty, 0);
        check("fw_q",       q,       32'h0);
        check("fw_rdusedw", rdusedw, 2);
        check("fw_wrusedw", wrusedw, 1);

        step(1'b0, 64'd0, 1'b1);
        check("rd1_q",       q,       32'h1);
        check("rd1_rdusedw", rdusedw, 1);
        check("rd1_wrusedw", wrusedw, 0);

        step(1'b0, 64'd0, 1'b1);
        check("rd2_rdempty", rdempty, 1);
        check("rd2_rdusedw", rdusedw, 0);

        // Underflow: read on empty changes nothing
        step(1'b0, 64'd0, 1'b1);
        check("udf_rdempty", rdempty, 1);
        check("udf_wrempty", wrempty, 1);
        check("udf_rdusedw", rdusedw, 0);
        check("udf_wrusedw", wrusedw, 0);
        check("udf_q",       q,       0);
`ifdef DCFIFO_MW_ERRFLAG_EN
        check("udf_flag",    underflow, 1);
`endif

        // Fill to capacity, then overflow attempt
        do_reset();
        fill_all();
        check("full_wrfull",  wrfull,  1);
        check("full_rdfull",  rdfull,  1);
        check("full_wrusedw", wrusedw, 0);
        check("full_rdusedw", rdusedw, 0);
        check("full_wrempty", wrempty, 0);
        step(1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0);
        check("ovf_rdfull",  rdfull,  1);
        check("ovf_rdusedw", rdusedw, 0);
        check("ovf_q",       q,       0);
`ifdef DCFIFO_MW_ERRFLAG_EN
        check("ovf_flag",    overflow, 1);
`endif

        // Drain all 1024 read words in order
        for (int i = 0; i < 1024; i++) begin
            check("drain_q", q, 64'(i));
            step(1'b0, 64'd0, 1'b1);
        end
        check("drain_rdempty", rdempty, 1);
        check("drain_rdusedw", rdusedw, 0);

        // Simultaneous write+read at C=1023
        do_reset();
        fill_all();
        step(1'b0, 64'd0, 1'b1);
        check("c1023_rdusedw", rdusedw, 1023);
        check("c1023_wrfull",  wrfull,  1);
        step(1'b1, 64'h12345678_9ABCDEF0, 1'b1);
        check("c1022_rdusedw", rdusedw, 1022);
        check("c1022_wrusedw", wrusedw, 511);
        check("c1022_wrfull",  wrfull,  0);
        check("c1022_rdfull",  rdfull,  0);
        check("c1022_q",       q,       2);
        for (int i = 2; i < 1024; i++) begin
            check("tail_q", q, 64'(i));
            step(1'b0, 64'd0, 1'b1);
        end
        check("tail_rdempty", rdempty, 1);

        // Pointers have wrapped; new data must still come out intact
        step(1'b1, 64'h0000BBBB_0000AAAA, 1'b0);
        check("wrap_q_lo", q, 32'hAAAA);
        step(1'b0, 64'd0, 1'b1);
        check("wrap_q_hi", q, 32'hBBBB);
        step(1'b0, 64'd0, 1'b1);
        check("wrap_rdempty", rdempty, 1);

        // Reset while half full, with a write pending
        do_reset();
        for (int k = 0; k < 256; k++) begin
            step(1'b1, {32'(2 * k + 1), 32'(2 * k)}, 1'b0);
        end
        check("half_rdusedw", rdusedw, 512);
        check("half_wrusedw", wrusedw, 256);
        rst_n = 1'b0;
        step(1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        rst_n = 1'b1;
        check("mrst_rdempty", rdempty, 1);
        check("mrst_rdusedw", rdusedw, 0);
        check("mrst_wrusedw", wrusedw, 0);
        check("mrst_q",       q,       0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
